// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM request front-end: command op, FSM state, FIFO entry layout.
// The RB_WAIT state exists only when RAM_CTRL_RDBK_EN is defined.
package ram_ctrl_pkg;

    localparam int CMD_AW = 3;
    localparam int CMD_DW = 8;

    localparam logic RAM_WR_WRITE = 1'b0;
    localparam logic RAM_WR_READ  = 1'b1;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_WAIT  = 3'd2,
`ifdef RAM_CTRL_RDBK_EN
        ST_RB_WAIT  = 3'd4,
`endif
        ST_RSP_HOLD = 3'd3
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] data;
    } cmd_t;

endpackage

// File: rtl/ram_cmd_fifo.sv
// Command FIFO for ram_req_ctrl; pushes while full are refused, even when a pop
// happens in the same cycle, so the full flag alone decides acceptance.
module ram_cmd_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     push_cmd,
    input  logic                     pop,
    output cmd_t                     pop_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_cmd = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request front-end for ram_dut: buffers commands, issues them one at a time, returns read data.
// Define RAM_CTRL_RDBK_EN to read back every write and flag mismatches on err_mismatch.
//
// state       | meaning
// IDLE        | bus idle (ram_wr=1); pops the next command when the FIFO has one
// WR          | ram_wr=0 for exactly one cycle
// RD_WAIT     | read address on the bus, waiting for ram_rdata
// RSP_HOLD    | response pending on rsp_*; no new RAM command until it is taken
// RB_WAIT     | (RAM_CTRL_RDBK_EN) readback of the address just written
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int AW         = CMD_AW,
    parameter int DW         = CMD_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          err_mismatch
);

    localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
    // A read reaches the RAM one edge after RD_WAIT is entered, hence RD_LAT more cycles.
    localparam logic [2:0]  RD_TMR = 3'(RD_LAT);

    state_e          state_q, state_d;
    cmd_t            push_cmd, head;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic [2:0]      tmr_q;
    logic            capture;

    assign push_cmd.op   = op_e'(req_op);
    assign push_cmd.addr = CMD_AW'(req_addr);
    assign push_cmd.data = CMD_DW'(req_wdata);

    ram_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_valid),
        .push_cmd (push_cmd),
        .pop      (fifo_pop),
        .pop_cmd  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign req_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

`ifdef RAM_CTRL_RDBK_EN
    logic rb_check;
`endif

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
`ifdef RAM_CTRL_RDBK_EN
        rb_check = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = (head.op == OP_WR) ? ST_WR : ST_RD_WAIT;
                end
            end
            ST_WR: begin
`ifdef RAM_CTRL_RDBK_EN
                state_d = ST_RB_WAIT;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RD_WAIT: begin
                if (tmr_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RSP_HOLD;
                end
            end
            ST_RSP_HOLD: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef RAM_CTRL_RDBK_EN
            ST_RB_WAIT: begin
                if (tmr_q == '0) begin
                    rb_check = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ram_wr    <= RAM_WR_READ;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tmr_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q <= state_d;
            ram_wr  <= (state_d == ST_WR) ? RAM_WR_WRITE : RAM_WR_READ;
            if (fifo_pop) begin
                ram_addr  <= AW'(head.addr);
                ram_wdata <= DW'(head.data);
            end
            if (state_d == ST_RD_WAIT && state_q != ST_RD_WAIT) begin
                tmr_q <= RD_TMR;
`ifdef RAM_CTRL_RDBK_EN
            // Readback data rides the write edge itself, so one cycle less than a plain read.
            end else if (state_d == ST_RB_WAIT && state_q != ST_RB_WAIT) begin
                tmr_q <= RD_TMR - 3'd1;
`endif
            end else if (tmr_q != '0) begin
                tmr_q <= tmr_q - 3'd1;
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ram_rdata;
            end else if (state_q == ST_RSP_HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef RAM_CTRL_RDBK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch <= 1'b0;
        end else if (rb_check && (ram_rdata != ram_wdata)) begin
            err_mismatch <= 1'b1;
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule
